// File: rtl/tx_sched_pkg.sv
// Shared types, defaults and helpers for the TX packet scheduler.
package tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } sched_state_e;

  localparam int unsigned TX_NUM_SRC   = 3;
  localparam int unsigned TX_DATA_W    = 32;
  localparam int unsigned TX_MAX_BEATS = 512;
  localparam int unsigned TX_SRC_W     = $clog2(TX_NUM_SRC);

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry register FIFO; ready depends only on registered occupancy.
module axis_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [1:0]   count;
  logic [W-1:0] ent0;
  logic [W-1:0] ent1;
  logic         push;
  logic         pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = ent0;
  assign pop       = out_valid & out_ready;
  assign push      = in_valid & (in_ready | out_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 2'd0;
      ent0  <= '0;
      ent1  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) ent0 <= in_data;
          else               ent1 <= in_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            ent0 <= in_data;
          end else begin
            ent0 <= ent1;
            ent1 <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tx_pkt_sched.sv
// Round-robin whole-packet scheduler with beat watchdog and output skid buffer.
// Optional statistics counters are built when TX_SCHED_STATS_EN is defined.
module tx_pkt_sched
  import tx_sched_pkg::*;
#(
  parameter int unsigned NUM_SRC   = TX_NUM_SRC,
  parameter int unsigned DATA_W    = TX_DATA_W,
  parameter int unsigned MAX_BEATS = TX_MAX_BEATS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        s_tvalid,
  output logic [NUM_SRC-1:0]        s_tready,
  input  logic [NUM_SRC*DATA_W-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]        s_tlast,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [DATA_W-1:0]         m_tdata,
  output logic                      m_tlast,
  output logic [$clog2(NUM_SRC)-1:0] m_tsrc,
  output logic                      busy,
  output logic                      err_oversize,
  output logic [NUM_SRC*32-1:0]     stat_pkts,
  output logic [15:0]               stat_trunc
);

  localparam int unsigned SRC_W = $clog2(NUM_SRC);
  localparam int unsigned CNT_W = (MAX_BEATS == 0) ? 1 : $clog2(MAX_BEATS + 1);
  localparam int unsigned PAY_W = DATA_W + 1 + SRC_W;
  localparam bit          WD_EN = (MAX_BEATS != 0);

  typedef logic [SRC_W-1:0] src_t;

  sched_state_e state, state_nxt;
  src_t         grant, grant_nxt, rr_ptr, rr_nxt, arb_idx;
  logic [CNT_W-1:0] beat_cnt, cnt_nxt;
  logic         arb_hit;
  logic         sel_valid, sel_last, push, push_last, trunc;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] src_data [NUM_SRC];
  logic         sb_ready;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_split
    assign src_data[g] = s_tdata[g*DATA_W +: DATA_W];
  end

  assign sel_valid = s_tvalid[grant];
  assign sel_last  = s_tlast[grant];
  assign sel_data  = src_data[grant];
  assign busy      = (state != IDLE);

  // Walk the ring once starting after rr_ptr; first valid source wins.
  always_comb begin
    src_t cand;
    arb_hit = 1'b0;
    arb_idx = rr_ptr;
    cand    = rr_ptr;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      cand = src_t'(rr_next(32'(cand), NUM_SRC));
      if (!arb_hit && s_tvalid[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rr_nxt    = rr_ptr;
    cnt_nxt   = beat_cnt;
    trunc     = 1'b0;
    push      = 1'b0;
    push_last = sel_last;
    s_tready  = '0;
    case (state)
      IDLE: begin
        if (arb_hit) begin
          grant_nxt = arb_idx;
          rr_nxt    = arb_idx;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        s_tready[grant] = sb_ready;
        if (sel_valid && sb_ready) begin
          push    = 1'b1;
          cnt_nxt = (beat_cnt == '1) ? beat_cnt : beat_cnt + 1'b1;
          if (sel_last) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else if (WD_EN && (32'(beat_cnt) + 32'd1 == MAX_BEATS)) begin
            push_last = 1'b1;
            trunc     = 1'b1;
            cnt_nxt   = '0;
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        s_tready[grant] = 1'b1;
        if (sel_valid && sel_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      grant        <= '0;
      rr_ptr       <= src_t'(NUM_SRC - 1);
      beat_cnt     <= '0;
      err_oversize <= 1'b0;
    end else begin
      state        <= state_nxt;
      grant        <= grant_nxt;
      rr_ptr       <= rr_nxt;
      beat_cnt     <= cnt_nxt;
      err_oversize <= trunc;
    end
  end

  axis_skid_buf #(.W(PAY_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (push),
    .in_ready  (sb_ready),
    .in_data   ({grant, push_last, sel_data}),
    .out_valid (m_tvalid),
    .out_ready (m_tready),
    .out_data  ({m_tsrc, m_tlast, m_tdata})
  );

`ifdef TX_SCHED_STATS_EN
  logic pkt_done;
  assign pkt_done = sel_valid && sel_last &&
                    ((state == STREAM && sb_ready) || state == DRAIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_pkts  <= '0;
      stat_trunc <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (pkt_done && grant == src_t'(i))
          stat_pkts[i*32 +: 32] <= stat_pkts[i*32 +: 32] + 32'd1;
      end
      if (trunc) stat_trunc <= stat_trunc + 16'd1;
    end
  end
`else
  assign stat_pkts  = '0;
  assign stat_trunc = '0;
`endif

endmodule

// File: doc/tx_pkt_sched.md
# tx_pkt_sched

Round-robin packet scheduler that shares the Ethernet-bridge TX stream between NUM_SRC AXI-Stream packet sources (reconfiguration slots and the pass-through path). It grants whole packets, never interleaves beats of different packets, and re-registers the output through a two-entry skid buffer so the bridge sees a timing-clean interface. A per-packet beat watchdog truncates runaway packets so that one faulty slot cannot lock the link.

## Interface
- NUM_SRC, 3: number of source streams (2..8).
- DATA_W, 32: tdata width.
- MAX_BEATS, 512: maximum beats per packet. 0 disables the watchdog.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous and active-low.
- s_tvalid  in  NUM_SRC  per-source valid.
- s_tready  out  NUM_SRC  per-source ready.
- s_tdata  in  NUM_SRC*DATA_W  per-source data; source i occupies bits [i*DATA_W +: DATA_W].
- s_tlast  in  NUM_SRC  per-source end of packet.
- m_tvalid  out  1  valid to the bridge.
- m_tready  in  1  ready from the bridge.
- m_tdata  out  DATA_W  data to the bridge.
- m_tlast  out  1  end of packet to the bridge.
- m_tsrc  out  clog2(NUM_SRC)  index of the source that owns the current m_* beat.
- busy  out  1  high in STREAM or DRAIN.
- err_oversize  out  1  one-cycle pulse when a packet is truncated.

## Operation
- States:
  - IDLE: arbitration.
  - STREAM: forwarding the granted source.
  - DRAIN: discarding the tail of a truncated packet.
- IDLE:
  - The search starts at rr_ptr+1 mod NUM_SRC. The first source with s_tvalid=1 becomes grant, rr_ptr <= grant, and the block moves to STREAM.
  - If no source is valid, the block stays in IDLE.
  - s_tready is all zero in IDLE.
- STREAM:
  - s_tready[grant] = skid-buffer not full; all other readies are 0.
  - Each accepted beat is pushed into the skid buffer together with its source index, and beat_cnt increments.
  - If the accepted beat has tlast=1, beat_cnt is cleared and the next state is IDLE.
  - If the accepted beat has tlast=0 and beat_cnt+1 == MAX_BEATS (watchdog enabled):
    - the beat is pushed with tlast forced to 1;
    - err_oversize pulses;
    - the next state is DRAIN.
- DRAIN:
  - s_tready[grant] = 1. Beats are discarded and never pushed.
  - On an accepted beat with tlast=1, the next state is IDLE.
- Skid buffer: a 2-entry register FIFO. m_tvalid = not empty. A pop happens on m_tvalid & m_tready.
- Simultaneous push and pop on a full buffer is allowed. Ready is derived from registered occupancy only, never from m_tready combinationally.
- beat_cnt width is clog2(MAX_BEATS+1) and it saturates; it never wraps.
- A mid-packet drop of s_tvalid is legal. The grant is held indefinitely with no timeout on idle cycles.
- Async reset mid-packet:
  - the skid buffer is flushed;
  - the partial packet is lost downstream;
  - the next packet arbitrates from source 0.

## Timing
- Reset values:
  - outputs: s_tready=0, m_tvalid=0, m_tdata=0, m_tlast=0, m_tsrc=0, busy=0, err_oversize=0;
  - internal: state=IDLE, rr_ptr=NUM_SRC-1 (so source 0 wins first), beat_cnt=0.
- Latency: s_tvalid rising in IDLE at cycle 0 gives grant at edge 1, s_tready high in cycle 1, and the first beat on m_* in cycle 2.
- Packet gap: there is one input-side IDLE cycle between packets. With m_tready held at 1, the output gap is at most 1 cycle.
- Steady-state throughput is 1 beat/cycle while m_tready=1.
- m_* are held stable while m_tvalid & ~m_tready (AXI-Stream rule).
- err_oversize is asserted in the cycle after the truncating beat is accepted.

## Configuration
- TX_SCHED_STATS_EN defined adds:
  - per-source 32-bit counters stat_pkts[NUM_SRC*32] (packets completed on the input side, truncated ones included);
  - a 16-bit stat_trunc counter.
  - All counters are cleared on rst and wrap.
- TX_SCHED_STATS_EN undefined: the stat ports remain present and are tied to 0, and no counter logic is built.

## Structure
- tx_sched_pkg holds:
  - the state enum (IDLE, STREAM, DRAIN);
  - default NUM_SRC/DATA_W/MAX_BEATS constants;
  - the src index width constant;
  - the round-robin next-index function.
- Sub-module axis_skid_buf: a 2-entry register slice, parameterised on payload width. Its payload is DATA_W + 1 + src width.

## Test plan
- Single packet on src1 (4 beats, m_tready=1, 0x11..0x14) -> m_* carries 0x11..0x14 from cycle 2, m_tsrc=1, m_tlast on 0x14 only.
- All three sources valid with 2-beat packets -> grant order 0,1,2,0; no beat interleaving.
- m_tready toggling 1010 on an 8-beat packet -> all 8 beats delivered in order; m_tdata stable while stalled; no loss.
- MAX_BEATS=4 with a 7-beat packet on src2 -> 4 beats out with tlast on beat 4; err_oversize pulses once; 3 beats drained; then src0 is served.
- Reset asserted mid-packet on beat 3 -> all outputs go to 0 asynchronously; after release, src0 is granted first.
- TX_SCHED_STATS_EN defined, 5 packets on src1 -> stat_pkts[1]=5; the other counters stay 0.
